onehot_gen: RTL and testbench
=============================

Name: onehot_gen

Overview:
- Streaming index-to-onehot decoder; the inverse of the onehot-to-index encoder used by arbiters and priority logic.
- Accepts binary indices over a valid/ready handshake and presents registered onehot vectors downstream, with full-throughput backpressure via a 1-entry skid buffer.
- Used to drive select/grant vectors from index-producing logic such as counters, FSMs and FIFOs.

Parameters:
- WIDTH, 15, onehot vector width; must be 2 or more.
- (derived, not overridable) IDXW = $clog2(WIDTH), index width.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rstn  input  1  reset, synchronous, active-low.
- i_index  input  IDXW  binary index to decode.
- i_valid  input  1  upstream data valid.
- o_ready  output  1  block can accept; registered.
- o_onehot  output  WIDTH  decoded vector, registered.
- o_valid  output  1  downstream data valid.
- i_ready  input  1  downstream accept.
- o_error  output  1  index of current output was out of range; present only with the feature enabled, tied 0 otherwise.

Behaviour:
- One clock domain. Reset is synchronous and active-low: i_rstn sampled low at a rising edge of i_clk clears all state.
- Reset values: o_valid=0, o_onehot=0, o_error=0, o_ready=1, skid buffer empty.
- Transfer rules:
  - Input transfer happens when i_valid && o_ready.
  - Output transfer happens when o_valid && i_ready.
- Decode: bit k of the decoded vector is 1 iff i_index==k, for k < WIDTH. Indices >= WIDTH decode to all-zeros; this applies only when WIDTH is not a power of 2.
- Latency: exactly 1 cycle from an input transfer to o_valid/o_onehot when the output stage is empty or draining.
- State, two registers:
  - OUT: o_onehot, o_error, o_valid.
  - SKID: onehot, error, full.
- Per-cycle update:
  - OUT empty, or OUT transferring out this cycle:
    - If SKID full, SKID moves to OUT and SKID clears.
    - Otherwise any input transfer loads OUT.
    - If both SKID moves and an input transfer occurs, the input goes to SKID.
  - OUT full and stalled (o_valid && !i_ready): an input transfer loads SKID.
  - o_ready (registered) = !SKID.full after the update. An input is never accepted while SKID is full.
- Throughput: one transfer per cycle sustained while i_ready=1.
- Ordering: strictly FIFO, no drops, no duplicates.
- Boundary conditions:
  - Stall, then release: drains SKID before any new input.
  - Simultaneous accept and drain with SKID full: impossible, because o_ready=0.
  - i_valid while o_ready=0: input is ignored and must be held by upstream.
  - Reset mid-stream discards both stages; o_valid=0 next cycle.
  - o_onehot is don't-care-stable: it holds its value while o_valid=0 and is not cleared.
- o_onehot while o_valid=1 always has popcount 1, or 0 for an out-of-range index.

Optional Feature:
- Macro: ONEHOT_GEN_RANGECHECK_EN.
- Defined:
  - An index >= WIDTH produces o_onehot=0 with o_error=1 for that output beat.
  - o_error travels through SKID aligned with its vector.
- Undefined:
  - No error path; o_error is tied 0 and SKID.error is not instantiated.
  - Out-of-range indices still decode to all-zeros.
- The feature has no effect when WIDTH is a power of 2; o_error remains 0.

Decomposition:
- Shared package onehot_pkg holds:
  - the index-width helper constant/function (IDXW from WIDTH), shared with the onehot-to-index encoder;
  - the reset polarity constant.
- One natural sub-module: skid_buf, a generic 2-register valid/ready skid stage parameterised by data width, carrying {error, onehot}.
- Decode is a simple comparator loop in the top level.

Test Plan:
- WIDTH=5, reset asserted 3 cycles with i_valid=1 -> o_valid=0, o_onehot=5'b00000, o_ready=1 throughout; first edge after release accepts.
- WIDTH=5, i_ready=1, indices 0,1,2,3,4 back-to-back -> o_onehot 00001,00010,00100,01000,10000 on consecutive cycles, each 1 cycle after input; o_ready stays 1.
- WIDTH=5, indices 2,4,1 streamed, i_ready=0 for 3 cycles after the first output -> o_onehot holds 00100; SKID captures 4; o_ready=0; index 1 held upstream; on release outputs 10000 then 00010; no loss.
- WIDTH=5 with ONEHOT_GEN_RANGECHECK_EN, index 6 -> o_onehot=00000, o_error=1 for that beat only; next index 0 -> 00001, o_error=0.
- WIDTH=8, random indices and random i_valid/i_ready over 10k cycles -> output sequence matches a scoreboard model; popcount=1 on every beat; o_error never 1.
- Reset asserted while SKID is full and OUT is stalled -> next cycle o_valid=0, o_ready=1; post-reset stream starts clean.

Source files
------------

// File: rtl/onehot_pkg.sv
// Shared definitions for the onehot encoder/decoder family: index-width helper
// and reset polarity.
package onehot_pkg;

    // Reset is active-low throughout the family.
    localparam logic RST_ACTIVE = 1'b0;

    // Bits needed to address a vector of the given width (never less than 1).
    function automatic int idx_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/onehot_gen_skid_buf.sv
// Generic two-register valid/ready stage: an output register plus a one-entry
// skid register, giving full throughput with a registered ready.
module skid_buf
    import onehot_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic [DW-1:0] i_data,
    input  logic          i_valid,
    output logic          o_ready,
    output logic [DW-1:0] o_data,
    output logic          o_valid,
    input  logic          i_ready
);

    logic [DW-1:0] out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] skid_data_q, skid_data_d;
    logic          skid_full_q, skid_full_d;
    logic          ready_q, ready_d;
    logic          in_xfer;
    logic          out_free;

    // NOTE: combinational blocks use blocking '=' with every output defaulted
    // first, so no latch is inferred; only the always_ff blocks use '<='.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        skid_data_d = skid_data_q;
        skid_full_d = skid_full_q;
        in_xfer     = i_valid && ready_q;
        out_free    = !out_valid_q || i_ready;

        if (out_free) begin
            if (skid_full_q) begin
                // Skid entry is older than any new input, so it drains first.
                out_data_d  = skid_data_q;
                out_valid_d = 1'b1;
                skid_full_d = in_xfer;
                if (in_xfer) begin
                    skid_data_d = i_data;
                end
            end else if (in_xfer) begin
                out_data_d  = i_data;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_xfer) begin
            skid_data_d = i_data;
            skid_full_d = 1'b1;
        end

        ready_d = !skid_full_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_rstn == RST_ACTIVE) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            skid_full_q <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            skid_full_q <= skid_full_d;
            ready_q     <= ready_d;
        end
    end

    // NOTE: the skid payload has no reset; it is only ever read while
    // skid_full_q is set, and skid_full_q is reset.
    always_ff @(posedge i_clk) begin
        skid_data_q <= skid_data_d;
    end

    assign o_data  = out_data_q;
    assign o_valid = out_valid_q;
    assign o_ready = ready_q;

endmodule

// File: rtl/onehot_gen.sv
// Streaming binary-index to onehot decoder with a registered skid-buffered
// output. Define ONEHOT_GEN_RANGECHECK_EN to flag out-of-range indices on o_error.
module onehot_gen
    import onehot_pkg::*;
#(
    parameter  int WIDTH = 15,
    localparam int IDXW  = idx_width(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic [IDXW-1:0]  i_index,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_onehot,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_error
);

    logic [WIDTH-1:0] decoded;

    // Indices at or above WIDTH match no bit and fall out as all-zeros.
    always_comb begin
        decoded = '0;
        for (int k = 0; k < WIDTH; k++) begin
            decoded[k] = (i_index == IDXW'(k));
        end
    end

`ifdef ONEHOT_GEN_RANGECHECK_EN
    localparam int DW = WIDTH + 1;

    logic [DW-1:0] in_data;
    logic [DW-1:0] out_data;

    // An empty decode is exactly the out-of-range case; never true when
    // WIDTH is a power of 2.
    assign in_data  = {~|decoded, decoded};
    assign o_error  = out_data[WIDTH];
    assign o_onehot = out_data[WIDTH-1:0];
`else
    localparam int DW = WIDTH;

    logic [DW-1:0] in_data;
    logic [DW-1:0] out_data;

    assign in_data  = decoded;
    assign o_error  = 1'b0;
    assign o_onehot = out_data;
`endif

    skid_buf #(
        .DW (DW)
    ) u_skid (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_data  (in_data),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_data  (out_data),
        .o_valid (o_valid),
        .i_ready (i_ready)
    );

endmodule

// File: tb/tb_onehot_gen.sv
// Self-checking bench for onehot_gen: a WIDTH=5 instance for directed cases and
// a WIDTH=8 instance for randomized streaming, both scored against a queue model.
module tb_onehot_gen;

`ifdef ONEHOT_GEN_RANGECHECK_EN
    localparam logic RC = 1'b1;
`else
    localparam logic RC = 1'b0;
`endif

    typedef struct packed {
        logic       err;
        logic [4:0] oh;
    } exp5_t;

    logic       clk = 1'b0;
    logic       rstn;

    logic [2:0] idx5;
    logic       v5, rdy5, orr5, ov5, oe5;
    logic [4:0] oh5;

    logic [2:0] idx8;
    logic       v8, rdy8, orr8, ov8, oe8;
    logic [7:0] oh8;

    int checks = 0;
    int errors = 0;

    exp5_t      q5[$];
    logic [7:0] q8[$];

    always #5 clk = ~clk;

    onehot_gen #(.WIDTH(5)) u_dut5 (
        .i_clk    (clk),
        .i_rstn   (rstn),
        .i_index  (idx5),
        .i_valid  (v5),
        .o_ready  (orr5),
        .o_onehot (oh5),
        .o_valid  (ov5),
        .i_ready  (rdy5),
        .o_error  (oe5)
    );

    onehot_gen #(.WIDTH(8)) u_dut8 (
        .i_clk    (clk),
        .i_rstn   (rstn),
        .i_index  (idx8),
        .i_valid  (v8),
        .o_ready  (orr8),
        .o_onehot (oh8),
        .o_valid  (ov8),
        .i_ready  (rdy8),
        .o_error  (oe8)
    );

    function automatic exp5_t model5(input logic [2:0] i);
        exp5_t e;
        e.oh  = (i < 3'd5) ? (5'b00001 << i) : 5'b00000;
        e.err = (i >= 3'd5) ? RC : 1'b0;
        return e;
    endfunction

    // Scoreboard: inputs are scored at the falling edge before the rising edge
    // that transfers them; outputs are popped on the same basis.
    always @(negedge clk) begin
        exp5_t      e5;
        logic [7:0] e8;
        #1;
        if (!rstn) begin
            q5.delete();
            q8.delete();
        end else begin
            if (ov5 && rdy5) begin
                checks++;
                if (q5.size() == 0) begin
                    errors++;
                    $display("FAIL sb5_unexpected got oh=%b err=%b, queue empty", oh5, oe5);
                end else begin
                    e5 = q5.pop_front();
                    if ({oe5, oh5} !== e5) begin
                        errors++;
                        $display("FAIL sb5_data got err=%b oh=%b expected err=%b oh=%b",
                                 oe5, oh5, e5.err, e5.oh);
                    end
                end
            end
            if (v5 && orr5) q5.push_back(model5(idx5));

            if (ov8 && rdy8) begin
                checks++;
                if (q8.size() == 0) begin
                    errors++;
                    $display("FAIL sb8_unexpected got oh=%b, queue empty", oh8);
                end else begin
                    e8 = q8.pop_front();
                    if (oh8 !== e8 || $countones(oh8) != 1 || oe8 !== 1'b0) begin
                        errors++;
                        $display("FAIL sb8_data got oh=%b err=%b expected oh=%b err=0",
                                 oh8, oe8, e8);
                    end
                end
            end
            if (v8 && orr8) q8.push_back(8'b00000001 << idx8);
        end
    end

    task automatic drive5(input logic v, input logic [2:0] i, input logic r);
        @(negedge clk);
        v5   = v;
        idx5 = i;
        rdy5 = r;
    endtask

    task automatic test_reset;
        repeat (3) begin
            @(negedge clk);
            #2;
            checks++;
            if (ov5 !== 1'b0 || oh5 !== 5'b00000 || orr5 !== 1'b1) begin
                errors++;
                $display("FAIL reset_state got v=%b oh=%b rdy=%b expected v=0 oh=00000 rdy=1",
                         ov5, oh5, orr5);
            end
        end
        checks++;
        if (ov8 !== 1'b0 || oh8 !== 8'h00 || orr8 !== 1'b1 || oe8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state8 got v=%b oh=%b rdy=%b err=%b", ov8, oh8, orr8, oe8);
        end
        @(negedge clk);
        rstn = 1'b1;
        drive5(1'b0, 3'd0, 1'b1);
        #2;
        checks++;
        if (ov5 !== 1'b1 || oh5 !== 5'b01000) begin
            errors++;
            $display("FAIL reset_first_accept got v=%b oh=%b expected v=1 oh=01000", ov5, oh5);
        end
    endtask

    task automatic test_back_to_back;
        for (int k = 0; k <= 5; k++) begin
            drive5(k < 5, 3'(k), 1'b1);
            #2;
            checks++;
            if (orr5 !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready k=%0d got %b expected 1", k, orr5);
            end
            if (k > 0) begin
                checks++;
                if (ov5 !== 1'b1 || oh5 !== (5'b00001 << (k - 1))) begin
                    errors++;
                    $display("FAIL b2b_data k=%0d got v=%b oh=%b expected v=1 oh=%b",
                             k, ov5, oh5, 5'b00001 << (k - 1));
                end
            end
        end
        drive5(1'b0, 3'd0, 1'b1);
    endtask

    task automatic test_stall;
        drive5(1'b1, 3'd2, 1'b1);
        drive5(1'b1, 3'd4, 1'b0);
        #2;
        checks++;
        if (ov5 !== 1'b1 || oh5 !== 5'b00100 || orr5 !== 1'b1) begin
            errors++;
            $display("FAIL stall_first got v=%b oh=%b rdy=%b expected 1 00100 1", ov5, oh5, orr5);
        end
        for (int c = 0; c < 3; c++) begin
            drive5(1'b1, 3'd1, c == 2);
            #2;
            checks++;
            if (ov5 !== 1'b1 || oh5 !== 5'b00100 || orr5 !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold c=%0d got v=%b oh=%b rdy=%b expected 1 00100 0",
                         c, ov5, oh5, orr5);
            end
        end
        drive5(1'b1, 3'd1, 1'b1);
        #2;
        checks++;
        if (ov5 !== 1'b1 || oh5 !== 5'b10000 || orr5 !== 1'b1) begin
            errors++;
            $display("FAIL stall_skid_drain got v=%b oh=%b rdy=%b expected 1 10000 1",
                     ov5, oh5, orr5);
        end
        drive5(1'b0, 3'd0, 1'b1);
        #2;
        checks++;
        if (ov5 !== 1'b1 || oh5 !== 5'b00010) begin
            errors++;
            $display("FAIL stall_held_input got v=%b oh=%b expected 1 00010", ov5, oh5);
        end
        drive5(1'b0, 3'd0, 1'b1);
        #2;
        checks++;
        if (ov5 !== 1'b0 || oh5 !== 5'b00010) begin
            errors++;
            $display("FAIL stall_idle_hold got v=%b oh=%b expected 0 00010", ov5, oh5);
        end
    endtask

    task automatic test_range;
        drive5(1'b1, 3'd6, 1'b1);
        drive5(1'b1, 3'd0, 1'b1);
        #2;
        checks++;
        if (ov5 !== 1'b1 || oh5 !== 5'b00000 || oe5 !== RC) begin
            errors++;
            $display("FAIL range_oob got v=%b oh=%b err=%b expected 1 00000 %b",
                     ov5, oh5, oe5, RC);
        end
        drive5(1'b0, 3'd0, 1'b1);
        #2;
        checks++;
        if (ov5 !== 1'b1 || oh5 !== 5'b00001 || oe5 !== 1'b0) begin
            errors++;
            $display("FAIL range_next got v=%b oh=%b err=%b expected 1 00001 0", ov5, oh5, oe5);
        end
        drive5(1'b0, 3'd0, 1'b1);
    endtask

    task automatic test_reset_mid;
        drive5(1'b1, 3'd3, 1'b1);
        drive5(1'b1, 3'd0, 1'b0);
        drive5(1'b1, 3'd2, 1'b0);
        #2;
        checks++;
        if (orr5 !== 1'b0 || ov5 !== 1'b1) begin
            errors++;
            $display("FAIL mid_full got rdy=%b v=%b expected rdy=0 v=1", orr5, ov5);
        end
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        v5   = 1'b0;
        rdy5 = 1'b1;
        #2;
        checks++;
        if (ov5 !== 1'b0 || orr5 !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset got v=%b rdy=%b expected v=0 rdy=1", ov5, orr5);
        end
        drive5(1'b1, 3'd1, 1'b1);
        drive5(1'b0, 3'd0, 1'b1);
        #2;
        checks++;
        if (ov5 !== 1'b1 || oh5 !== 5'b00010) begin
            errors++;
            $display("FAIL mid_restart got v=%b oh=%b expected 1 00010", ov5, oh5);
        end
        drive5(1'b0, 3'd0, 1'b1);
    endtask

    task automatic test_random;
        logic acc;
        acc = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            if (acc) begin
                v8   = ($urandom_range(0, 3) != 0);
                idx8 = 3'($urandom_range(0, 7));
            end
            rdy8 = ($urandom_range(0, 2) != 0);
            #2;
            acc = !(v8 && !orr8);
        end
        @(negedge clk);
        v8   = 1'b0;
        rdy8 = 1'b1;
    endtask

    task automatic test_drain;
        int n;
        n = 0;
        while ((q5.size() != 0 || q8.size() != 0 || ov5 || ov8) && n < 50) begin
            @(negedge clk);
            n++;
        end
        #2;
        checks++;
        if (q5.size() != 0 || q8.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout left q5=%0d q8=%0d expected 0 0", q5.size(), q8.size());
        end
    endtask

    initial begin
        rstn = 1'b0;
        v5   = 1'b1;
        idx5 = 3'd3;
        rdy5 = 1'b1;
        v8   = 1'b0;
        idx8 = 3'd0;
        rdy8 = 1'b1;

        test_reset();
        test_back_to_back();
        test_stall();
        test_range();
        test_reset_mid();
        test_random();
        test_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
